// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : motor_ramp_ctrl
//  Purpose  : Command-conditioning stage in front of the PWM motor driver.
//             Accepts signed speed commands over valid/ready, slew-limits
//             the duty cycle, and sequences direction reversals as
//             decelerate -> dead time (enable low) -> flip -> accelerate.
//  Ports    : clk, rst        clock, asynchronous active-high reset
//             estop           emergency stop (only with MOTOR_RAMP_ESTOP_EN)
//             cmd_valid/ready speed command handshake
//             cmd_speed[8:0]  signed speed, sign = direction, |x| = duty
//             duty_cycle[7:0] duty to the PWM driver
//             direction       1 = forward, 0 = reverse
//             enable          driver enable
//             at_target       settled at commanded duty/direction
//             busy            inverse of at_target
//  Options  : define MOTOR_RAMP_ESTOP_EN to add the estop input and logic.
//  Revision : 1.0 - initial release
// ============================================================================
module motor_ramp_ctrl #(
    parameter int STEP_DIV   = 1000,  // clocks per ramp tick (>= 1)
    parameter int STEP       = 4,     // duty change per tick (1..255)
    parameter int DEAD_TICKS = 8      // enable-low ticks before a flip (>= 1)
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MOTOR_RAMP_ESTOP_EN
    input  logic       estop,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [8:0] cmd_speed,
    output logic [7:0] duty_cycle,
    output logic       direction,
    output logic       enable,
    output logic       at_target,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int             c_PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(STEP_DIV - 1);
    localparam int             c_DW    = $clog2(DEAD_TICKS + 1);
    localparam logic [c_DW-1:0] c_DEAD = c_DW'(DEAD_TICKS);
    localparam logic [c_DW-1:0] c_DONE = c_DW'(1);
    localparam logic [7:0]     c_STEP  = 8'(STEP);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RAMP    = 3'd1;
    localparam logic [2:0] c_HOLD    = 3'd2;
    localparam logic [2:0] c_REVERSE = 3'd3;
    localparam logic [2:0] c_DEADT   = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [7:0]      r_duty;
    logic            r_dir;
    logic [7:0]      r_tgt_mag;
    logic            r_tgt_dir;
    logic [c_PW-1:0] r_presc;
    logic [c_DW-1:0] r_dead_cnt;

    logic [2:0]      w_state_nxt;
    logic [7:0]      w_duty_nxt;
    logic            w_dir_nxt;
    logic [c_DW-1:0] w_dead_nxt;

    logic            w_tick;
    logic            w_accept;
    logic [8:0]      w_cmd_abs;
    logic [7:0]      w_cmd_mag;
    logic            w_dir_mis;
    logic            w_tgt_nz;
    logic [7:0]      w_step_tgt;
    logic [7:0]      w_step_zero;

    // Move cur toward goal by at most STEP; lands exactly on goal when closer.
    function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] goal);
        logic [7:0] diff;
        if (cur < goal) begin
            diff   = goal - cur;
            f_step = (diff > c_STEP) ? cur + c_STEP : goal;
        end else begin
            diff   = cur - goal;
            f_step = (diff > c_STEP) ? cur - c_STEP : goal;
        end
    endfunction

    // ------------------------------------------------------------------
    // Free-running tick prescaler
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_PMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Command capture
    // ------------------------------------------------------------------
`ifdef MOTOR_RAMP_ESTOP_EN
    assign cmd_ready = (r_state != c_DEADT) && !estop;
`else
    assign cmd_ready = (r_state != c_DEADT);
`endif
    assign w_accept  = cmd_valid && cmd_ready;

    // -256 has magnitude 256, which saturates to full duty.
    assign w_cmd_abs = cmd_speed[8] ? (~cmd_speed + 9'd1) : cmd_speed;
    assign w_cmd_mag = w_cmd_abs[8] ? 8'hFF : w_cmd_abs[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt_mag <= 8'd0;
            r_tgt_dir <= 1'b1;
        end else begin
`ifdef MOTOR_RAMP_ESTOP_EN
            if (estop) begin
                r_tgt_mag <= 8'd0;
            end else
`endif
            if (w_accept) begin
                r_tgt_mag <= w_cmd_mag;
                // A zero command carries no sign information; keep the old one.
                if (w_cmd_abs != 9'd0) begin
                    r_tgt_dir <= ~cmd_speed[8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Ramp / reversal state machine
    // ------------------------------------------------------------------
    assign w_dir_mis   = (r_tgt_dir != r_dir);
    assign w_tgt_nz    = (r_tgt_mag != 8'd0);
    assign w_step_tgt  = f_step(r_duty, r_tgt_mag);
    assign w_step_zero = f_step(r_duty, 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        w_dead_nxt  = r_dead_cnt;

        case (r_state)
            c_IDLE: begin
                w_duty_nxt = 8'd0;
                if (w_tgt_nz) begin
                    if (w_dir_mis) begin
                        w_state_nxt = c_DEADT;
                        w_dead_nxt  = c_DEAD;
                    end else begin
                        w_state_nxt = c_RAMP;
                    end
                end
            end

            c_RAMP: begin
                if (w_dir_mis && w_tgt_nz) begin
                    w_state_nxt = c_REVERSE;
                end else if (w_tick) begin
                    w_duty_nxt = w_step_tgt;
                    if (w_step_tgt == r_tgt_mag) begin
                        w_state_nxt = w_tgt_nz ? c_HOLD : c_IDLE;
                    end
                end
            end

            c_HOLD: begin
                if (w_dir_mis && w_tgt_nz) begin
                    w_state_nxt = c_REVERSE;
                end else if (r_tgt_mag != r_duty) begin
                    w_state_nxt = c_RAMP;
                end
            end

            c_REVERSE: begin
                // A command that cancels the reversal returns to a normal
                // ramp from the current duty without any dead time.
                if (!w_dir_mis || !w_tgt_nz) begin
                    w_state_nxt = c_RAMP;
                end else begin
                    if (w_tick) begin
                        w_duty_nxt = w_step_zero;
                    end
                    if ((w_tick ? w_step_zero : r_duty) == 8'd0) begin
                        w_state_nxt = c_DEADT;
                        w_dead_nxt  = c_DEAD;
                    end
                end
            end

            c_DEADT: begin
                w_duty_nxt = 8'd0;
                if (w_tick) begin
                    if (r_dead_cnt <= c_DONE) begin
                        w_dead_nxt  = '0;
                        w_dir_nxt   = r_tgt_dir;
                        w_state_nxt = w_tgt_nz ? c_RAMP : c_IDLE;
                    end else begin
                        w_dead_nxt = r_dead_cnt - c_DONE;
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_duty_nxt  = 8'd0;
            end
        endcase

`ifdef MOTOR_RAMP_ESTOP_EN
        // Emergency stop overrides everything but keeps the last direction.
        if (estop) begin
            w_state_nxt = c_IDLE;
            w_duty_nxt  = 8'd0;
            w_dir_nxt   = r_dir;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_duty     <= 8'd0;
            r_dir      <= 1'b1;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_dir      <= w_dir_nxt;
            r_dead_cnt <= w_dead_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so glitch-free)
    // ------------------------------------------------------------------
    assign duty_cycle = r_duty;
    assign direction  = r_dir;
    assign enable     = (r_state == c_RAMP) || (r_state == c_HOLD) ||
                        (r_state == c_REVERSE);
    assign at_target  = (r_state == c_IDLE) || (r_state == c_HOLD);
    assign busy       = ~at_target;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_ramp_ctrl
//  Purpose  : Directed self-checking bench for motor_ramp_ctrl
//             (STEP_DIV=4, STEP=4, DEAD_TICKS=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_ctrl;

    localparam int c_STEP_DIV = 4;
    localparam int c_STEP     = 4;
    localparam int c_DEAD     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_speed;
    logic [7:0] duty_cycle;
    logic       direction;
    logic       enable;
    logic       at_target;
    logic       busy;
`ifdef MOTOR_RAMP_ESTOP_EN
    logic       estop;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    motor_ramp_ctrl #(
        .STEP_DIV   (c_STEP_DIV),
        .STEP       (c_STEP),
        .DEAD_TICKS (c_DEAD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MOTOR_RAMP_ESTOP_EN
        .estop      (estop),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_speed  (cmd_speed),
        .duty_cycle (duty_cycle),
        .direction  (direction),
        .enable     (enable),
        .at_target  (at_target),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge: drive for one clock, release at next negedge.
    task automatic send_cmd(input logic [8:0] s);
        cmd_valid = 1'b1;
        cmd_speed = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Watches outputs until busy has been seen and at_target returns.
    task automatic observe(input int max_cyc, output int ups, output int downs,
                           output int odd_steps, output int last_delta,
                           output int dead_cyc, output int dead_bad,
                           output int dir_flips, output bit timeout);
        int   prev_duty;
        logic prev_dir;
        bit   started;
        ups = 0; downs = 0; odd_steps = 0; last_delta = 0;
        dead_cyc = 0; dead_bad = 0; dir_flips = 0; timeout = 1'b1;
        prev_duty = int'(duty_cycle);
        prev_dir  = direction;
        started   = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (int'(duty_cycle) > prev_duty) begin
                ups++;
                last_delta = int'(duty_cycle) - prev_duty;
                if (last_delta != c_STEP) odd_steps++;
            end else if (int'(duty_cycle) < prev_duty) begin
                downs++;
                last_delta = prev_duty - int'(duty_cycle);
                if (last_delta != c_STEP) odd_steps++;
            end
            if (direction !== prev_dir) dir_flips++;
            if (busy && !enable) begin
                dead_cyc++;
                if (cmd_ready !== 1'b0 || duty_cycle !== 8'd0) dead_bad++;
            end
            prev_duty = int'(duty_cycle);
            prev_dir  = direction;
            if (busy) started = 1'b1;
            if (started && at_target) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_speed = 9'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec_cnt++; if (duty_cycle !== 8'd0) begin err_cnt++; $display("FAIL reset_duty: got %0d expected 0", duty_cycle); end
        vec_cnt++; if (direction !== 1'b1) begin err_cnt++; $display("FAIL reset_dir: got %b expected 1", direction); end
        vec_cnt++; if (enable !== 1'b0) begin err_cnt++; $display("FAIL reset_enable: got %b expected 0", enable); end
        vec_cnt++; if (at_target !== 1'b1) begin err_cnt++; $display("FAIL reset_at_target: got %b expected 1", at_target); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp_up();
        int u, d, o, l, dc, db, df; bit to;
        send_cmd(9'd100);
        @(negedge clk);
        vec_cnt++; if (enable !== 1'b1) begin err_cnt++; $display("FAIL ramp_enable_rise: got %b expected 1", enable); end
        vec_cnt++; if (duty_cycle !== 8'd0) begin err_cnt++; $display("FAIL ramp_start_duty: got %0d expected 0", duty_cycle); end
        observe(400, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL ramp_timeout: got timeout expected settle"); end
        vec_cnt++; if (u != 25) begin err_cnt++; $display("FAIL ramp_ticks: got %0d expected 25", u); end
        vec_cnt++; if (o != 0 || d != 0) begin err_cnt++; $display("FAIL ramp_step_shape: got odd=%0d downs=%0d expected 0/0", o, d); end
        vec_cnt++; if (duty_cycle !== 8'd100) begin err_cnt++; $display("FAIL ramp_final_duty: got %0d expected 100", duty_cycle); end
        vec_cnt++; if (direction !== 1'b1 || enable !== 1'b1) begin err_cnt++; $display("FAIL ramp_dir_en: got dir=%b en=%b expected 1/1", direction, enable); end
    endtask

    task automatic test_partial_step();
        int u, d, o, l, dc, db, df; bit to;
        send_cmd(9'd102);
        observe(100, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to || u != 1 || l != 2) begin err_cnt++; $display("FAIL partial_step: got to=%0d ups=%0d delta=%0d expected 0/1/2", to, u, l); end
        vec_cnt++; if (duty_cycle !== 8'd102) begin err_cnt++; $display("FAIL partial_duty: got %0d expected 102", duty_cycle); end
        send_cmd(9'd100);
        observe(100, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to || d != 1 || duty_cycle !== 8'd100) begin err_cnt++; $display("FAIL partial_back: got to=%0d downs=%0d duty=%0d expected 0/1/100", to, d, duty_cycle); end
    endtask

    task automatic test_reverse();
        int u, d, o, l, dc, db, df; bit to;
        send_cmd(9'h1CE);  // -50
        observe(600, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL rev_timeout: got timeout expected settle"); end
        vec_cnt++; if (d != 25) begin err_cnt++; $display("FAIL rev_down_ticks: got %0d expected 25", d); end
        vec_cnt++; if (dc != c_DEAD * c_STEP_DIV || db != 0) begin err_cnt++; $display("FAIL rev_dead: got cycles=%0d bad=%0d expected 8/0", dc, db); end
        vec_cnt++; if (u != 13 || l != 2 || o != 1) begin err_cnt++; $display("FAIL rev_up_ramp: got ups=%0d last=%0d odd=%0d expected 13/2/1", u, l, o); end
        vec_cnt++; if (direction !== 1'b0 || df != 1) begin err_cnt++; $display("FAIL rev_dir: got dir=%b flips=%0d expected 0/1", direction, df); end
        vec_cnt++; if (duty_cycle !== 8'd50 || enable !== 1'b1) begin err_cnt++; $display("FAIL rev_final: got duty=%0d en=%b expected 50/1", duty_cycle, enable); end
    endtask

    task automatic test_full_reverse();
        int u, d, o, l, dc, db, df; bit to;
        do_reset();
        send_cmd(9'h100);  // -256
        observe(700, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL full_timeout: got timeout expected settle"); end
        vec_cnt++; if (dc < (c_DEAD - 1) * c_STEP_DIV + 1 || dc > c_DEAD * c_STEP_DIV || db != 0) begin err_cnt++; $display("FAIL full_dead: got cycles=%0d bad=%0d expected 5..8/0", dc, db); end
        vec_cnt++; if (u != 64 || l != 3 || o != 1 || d != 0) begin err_cnt++; $display("FAIL full_ramp: got ups=%0d last=%0d odd=%0d downs=%0d expected 64/3/1/0", u, l, o, d); end
        vec_cnt++; if (duty_cycle !== 8'd255 || direction !== 1'b0) begin err_cnt++; $display("FAIL full_final: got duty=%0d dir=%b expected 255/0", duty_cycle, direction); end
    endtask

    task automatic test_abort_and_reset();
        int u, d, o, l, dc, db, df; bit to; bit found;
        do_reset();
        send_cmd(9'd100);
        observe(400, u, d, o, l, dc, db, df, to);
        send_cmd(9'h1CE);  // -50
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (duty_cycle == 8'd60) begin found = 1'b1; break; end
            @(negedge clk);
        end
        vec_cnt++; if (!found || enable !== 1'b1 || cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_reach60: got found=%0d en=%b rdy=%b expected 1/1/1", found, enable, cmd_ready); end
        send_cmd(9'd80);
        observe(400, u, d, o, l, dc, db, df, to);
        vec_cnt++; if (to || dc != 0 || df != 0) begin err_cnt++; $display("FAIL abort_no_dead: got to=%0d dead=%0d flips=%0d expected 0/0/0", to, dc, df); end
        vec_cnt++; if (duty_cycle !== 8'd80 || direction !== 1'b1) begin err_cnt++; $display("FAIL abort_final: got duty=%0d dir=%b expected 80/1", duty_cycle, direction); end
        send_cmd(9'd200);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (duty_cycle > 8'd80) begin found = 1'b1; break; end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        vec_cnt++; if (!found || duty_cycle !== 8'd0 || enable !== 1'b0) begin err_cnt++; $display("FAIL midrst_duty_en: got found=%0d duty=%0d en=%b expected 1/0/0", found, duty_cycle, enable); end
        vec_cnt++; if (direction !== 1'b1 || at_target !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_flags: got dir=%b at=%b busy=%b rdy=%b expected 1/1/0/1", direction, at_target, busy, cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vec_cnt++; if (duty_cycle !== 8'd0 || enable !== 1'b0 || at_target !== 1'b1) begin err_cnt++; $display("FAIL midrst_discard: got duty=%0d en=%b at=%b expected 0/0/1", duty_cycle, enable, at_target); end
    endtask

`ifdef MOTOR_RAMP_ESTOP_EN
    task automatic test_estop();
        bit found;
        do_reset();
        send_cmd(9'd100);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (duty_cycle == 8'd40) begin found = 1'b1; break; end
            @(negedge clk);
        end
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_speed = 9'd120;
        #1;
        vec_cnt++; if (!found || cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL estop_ready: got found=%0d rdy=%b expected 1/0", found, cmd_ready); end
        @(negedge clk);
        vec_cnt++; if (duty_cycle !== 8'd0 || enable !== 1'b0 || at_target !== 1'b1) begin err_cnt++; $display("FAIL estop_stop: got duty=%0d en=%b at=%b expected 0/0/1", duty_cycle, enable, at_target); end
        estop     = 1'b0;
        cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        vec_cnt++; if (duty_cycle !== 8'd0 || enable !== 1'b0 || direction !== 1'b1) begin err_cnt++; $display("FAIL estop_ignored_cmd: got duty=%0d en=%b dir=%b expected 0/0/1", duty_cycle, enable, direction); end
    endtask
`endif

    initial begin
`ifdef MOTOR_RAMP_ESTOP_EN
        estop = 1'b0;
`endif
        test_reset();
        test_ramp_up();
        test_partial_step();
        test_reverse();
        test_full_reverse();
        test_abort_and_reset();
`ifdef MOTOR_RAMP_ESTOP_EN
        test_estop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
